// File: rtl/uart_rx_sampler_pkg.sv
// Shared serial definitions: receiver states, oversampling
// ratio and the baud divider calculation.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int OVS = 16;

   // Rounded clk/(baud*OVS), never below 1.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + (baud * OVS) / 2) / (baud * OVS);
      if (d < 1) d = 1;
      return d;
   endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receiver line/byte bundle. The slave side is the receiver,
// the master side drives the line and consumes the byte.
interface uart_rx_sampler_if;

   logic       rxd;
   logic       rxReady;
   logic [7:0] rxData;
   logic       rxFrameErr;
   logic       rxIdle;

   modport master (
      output rxd,
      input  rxReady,
      input  rxData,
      input  rxFrameErr,
      input  rxIdle
   );

   modport slave (
      input  rxd,
      output rxReady,
      output rxData,
      output rxFrameErr,
      output rxIdle
   );

endinterface

// File: rtl/uart_rx_sampler_tick.sv
// Free-running divider strobing one tick every DIV clocks,
// with a synchronous clear to realign the sampling phase.
module baud_tick_gen #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   // Count 0..DIV-1, wrapping on the tick or when cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 serial receiver, 16x oversampled with a 3-sample
// majority vote around mid-bit.
module uart_rx_sampler
   import serial_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input logic              clk,
   input logic              rst,
   uart_rx_sampler_if.slave bus
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);

   logic [1:0] sync;
   logic       rxs;
   rx_state_t  state;
   logic [3:0] scnt;
   logic [2:0] idx;
   logic [7:0] shreg;
   logic       s7;
   logic       s8;
   logic       tick;
   logic       clr;
   logic       mid;
   logic       vote;
   logic       rdy;
   logic [7:0] data;
   logic       ferr;
   logic       idle;

   assign rxs  = sync[1];
   assign clr  = (state == IDLE) && !rxs;
   assign mid  = tick && (scnt == 4'd9);
   assign vote = (s7 & s8) | (s7 & rxs) | (s8 & rxs);

   assign bus.rxReady    = rdy;
   assign bus.rxData     = data;
   assign bus.rxFrameErr = ferr;
   assign bus.rxIdle     = idle;

   baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sync <= 2'b11;
      else
         sync <= {sync[0], bus.rxd};
   end

   // Frame FSM: sampling, shifting and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         scnt  <= 4'd0;
         idx   <= 3'd0;
         shreg <= 8'd0;
         s7    <= 1'b1;
         s8    <= 1'b1;
         rdy   <= 1'b0;
         data  <= 8'd0;
         ferr  <= 1'b0;
         idle  <= 1'b1;
      end else begin
         rdy  <= 1'b0;
         ferr <= 1'b0;
         if (state != IDLE && state != BREAK && tick) begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd7) s7 <= rxs;
            if (scnt == 4'd8) s8 <= rxs;
         end
         unique case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
                  scnt  <= 4'd0;
                  idx   <= 3'd0;
                  idle  <= 1'b0;
               end
            end
            START: begin
               if (mid) begin
                  if (vote) begin
                     state <= IDLE;
                     idle  <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (mid) begin
                  shreg <= {vote, shreg[7:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (mid) begin
                  if (vote) begin
                     data  <= shreg;
                     rdy   <= 1'b1;
                     state <= IDLE;
                     idle  <= 1'b1;
                  end else begin
                     ferr  <= 1'b1;
                     state <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
                  idle  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               idle  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at DIV=2 (32 clk/bit).
// Line position i is driven on the i-th falling edge of a frame.
module tb_uart_rx_sampler;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_rx_sampler_if bus ();

   uart_rx_sampler #(
      .CLK_HZ (3_200_000),
      .BAUD   (100_000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int rdy_cnt = 0;
   int err_cnt = 0;
   int proto_bad = 0;
   logic [7:0] last_d = 8'h00;
   logic [7:0] prev_d = 8'h00;
   logic prev_rdy = 1'b0;
   logic prev_err = 1'b0;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.rxReady) begin
         rdy_cnt++;
         prev_d = last_d;
         last_d = bus.rxData;
      end
      if (bus.rxFrameErr) err_cnt++;
      if (bus.rxReady && bus.rxFrameErr) proto_bad++;
      if ((bus.rxReady && prev_rdy) || (bus.rxFrameErr && prev_err))
         proto_bad++;
      prev_rdy = bus.rxReady;
      prev_err = bus.rxFrameErr;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic line_at(input logic [7:0] d, input logic stp,
                                    input int i);
      if (i < 32) return 1'b0;
      if (i < 288) return d[(i - 32) / 32];
      return stp;
   endfunction

   task automatic idle_clks(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rxd = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stp,
                       input int stop_clks, input int g_at,
                       input int g_len);
      for (int i = 0; i < 288 + stop_clks; i++) begin
         @(negedge clk);
         if (i >= g_at && i < g_at + g_len)
            bus.rxd = 1'b0;
         else
            bus.rxd = line_at(d, stp, i);
      end
   endtask

   int r0;
   int e0;

   initial begin
      bus.rxd = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.rxReady, 0);
      chk("rst_data", bus.rxData, 0);
      chk("rst_ferr", bus.rxFrameErr, 0);
      chk("rst_idle", bus.rxIdle, 1);
      rst = 1'b0;
      idle_clks(10);

      // 1: single good frame
      r0 = rdy_cnt; e0 = err_cnt;
      send(8'h0A, 1'b1, 32, -1, 0);
      idle_clks(40);
      chk("t1_ready", rdy_cnt - r0, 1);
      chk("t1_data", bus.rxData, 8'h0A);
      chk("t1_ferr", err_cnt - e0, 0);

      // 2: back-to-back with a 0.6-bit stop
      r0 = rdy_cnt;
      send(8'h01, 1'b1, 19, -1, 0);
      send(8'h0F, 1'b1, 32, -1, 0);
      idle_clks(40);
      chk("t2_ready", rdy_cnt - r0, 2);
      chk("t2_first", prev_d, 8'h01);
      chk("t2_second", last_d, 8'h0F);

      // 3: short low glitch on an idle line
      r0 = rdy_cnt; e0 = err_cnt;
      repeat (10) begin
         @(negedge clk);
         bus.rxd = 1'b0;
      end
      idle_clks(60);
      chk("t3_ready", rdy_cnt - r0, 0);
      chk("t3_ferr", err_cnt - e0, 0);
      chk("t3_data", bus.rxData, 8'h0F);
      chk("t3_idle", bus.rxIdle, 1);

      // 4: framing error then break, then recovery
      r0 = rdy_cnt; e0 = err_cnt;
      send(8'h55, 1'b0, 32, -1, 0);
      repeat (40 * 32) begin
         @(negedge clk);
         bus.rxd = 1'b0;
      end
      chk("t4_busy", bus.rxIdle, 0);
      idle_clks(64);
      chk("t4_ferr", err_cnt - e0, 1);
      chk("t4_noready", rdy_cnt - r0, 0);
      chk("t4_idle", bus.rxIdle, 1);
      r0 = rdy_cnt;
      send(8'hA3, 1'b1, 32, -1, 0);
      idle_clks(40);
      chk("t4_ready", rdy_cnt - r0, 1);
      chk("t4_data", bus.rxData, 8'hA3);

      // 5: one-sample glitch at scnt 8 of data bit 1
      r0 = rdy_cnt;
      send(8'hC3, 1'b1, 32, 82, 2);
      idle_clks(40);
      chk("t5_ready", rdy_cnt - r0, 1);
      chk("t5_data", bus.rxData, 8'hC3);

      // 6: reset during data bit 4 of 0xFF
      r0 = rdy_cnt; e0 = err_cnt;
      for (int i = 0; i < 170; i++) begin
         @(negedge clk);
         bus.rxd = line_at(8'hFF, 1'b1, i);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_ready", bus.rxReady, 0);
      chk("t6_rst_data", bus.rxData, 0);
      chk("t6_rst_ferr", bus.rxFrameErr, 0);
      chk("t6_rst_idle", bus.rxIdle, 1);
      idle_clks(5);
      rst = 1'b0;
      idle_clks(200);
      chk("t6_noready", rdy_cnt - r0, 0);
      chk("t6_noferr", err_cnt - e0, 0);
      send(8'h12, 1'b1, 32, -1, 0);
      idle_clks(40);
      chk("t6_ready", rdy_cnt - r0, 1);
      chk("t6_data", bus.rxData, 8'h12);

      chk("pulse_rules", proto_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
